// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC engine and the
// planned parallel CRC, which reuses the same LFSR step.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } crc_state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Reflected polynomials; the top tap bit is implied by the LFSR.
    localparam logic [7:0]  CRC8_TAPS        = 8'hE0;
    localparam logic [7:0]  CRC8_SEED        = 8'h00;
    localparam logic [15:0] CRC16_CCITT_TAPS = 16'h8408;
    localparam logic [15:0] CRC16_CCITT_SEED = 16'hFFFF;
    localparam logic [31:0] CRC32_TAPS       = 32'hEDB88320;
    localparam logic [31:0] CRC32_SEED       = 32'hFFFFFFFF;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit of a reflected Galois LFSR: fb enters at the top stage and
// is XORed into every tapped stage on the way down.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   TAPS = 8'b01000100
) (
    input  logic [W-1:0] i_lfsr,
    input  logic         i_data,
    output logic [W-1:0] o_lfsr
);

    logic w_fb;

    assign w_fb   = i_data ^ i_lfsr[0];
    assign o_lfsr = {w_fb,
                     i_lfsr[W-1:1] ^ (TAPS[W-2:0] & {(W-1){w_fb}})};

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: folds a frame into the LFSR, then either
// streams the remainder out or compares it with the received CRC.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int unsigned          CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] TAPS      = 8'b01000100,
    parameter logic [CRC_WIDTH-1:0] SEED      = 8'hD8
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic Active,
    input  logic Mode,
    input  logic Data,
    output logic CRC,
    output logic Valid,
    output logic Done,
    output logic Err,
    output logic Busy
);

    localparam int unsigned      CNT_W    = $clog2(CRC_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_WIDTH);

    crc_state_e           r_state;
    crc_state_e           w_state_nx;
    logic [CRC_WIDTH-1:0] r_lfsr;
    logic [CRC_WIDTH-1:0] w_lfsr_nx;
    logic [CRC_WIDTH-1:0] w_step_in;
    logic [CRC_WIDTH-1:0] w_step_out;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic                 r_mode;
    logic                 w_mode_nx;
    logic                 r_mis;
    logic                 w_mis_nx;
    logic                 r_crc;
    logic                 w_crc_nx;
    logic                 r_valid;
    logic                 w_valid_nx;
    logic                 r_done;
    logic                 w_done_nx;
    logic                 r_err;
    logic                 w_err_nx;
    logic                 r_busy;

    logic w_in_out;
    logic w_last;
    logic w_start;
    logic w_calc;
    logic w_tail;
    logic w_finish;

    // Frame start and abort both restart from SEED with the current bit.
    assign w_step_in = (r_state == CALC) ? r_lfsr : SEED;

    crc_lfsr_step #(
        .W    (CRC_WIDTH),
        .TAPS (TAPS)
    ) u_step (
        .i_lfsr (w_step_in),
        .i_data (Data),
        .o_lfsr (w_step_out)
    );

    assign w_in_out = (r_state == OUT);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_start  = Active && (r_state == IDLE || w_in_out);
    assign w_calc   = Active && (r_state == CALC);
    assign w_tail   = !Active &&
                      (r_state == CALC || (w_in_out && !w_last));
    assign w_finish = !Active && w_in_out && w_last;

    always_comb begin
        w_state_nx = r_state;
        w_lfsr_nx  = r_lfsr;
        w_cnt_nx   = r_cnt;
        w_mode_nx  = r_mode;
        w_mis_nx   = r_mis;
        w_crc_nx   = 1'b0;
        w_valid_nx = 1'b0;
        w_done_nx  = 1'b0;
        w_err_nx   = r_err;
        unique case (1'b1)
            w_start: begin
                w_state_nx = CALC;
                w_lfsr_nx  = w_step_out;
                w_cnt_nx   = '0;
                w_mode_nx  = Mode;
                w_mis_nx   = 1'b0;
                w_err_nx   = 1'b0;
            end
            w_calc: begin
                w_lfsr_nx = w_step_out;
            end
            w_tail: begin
                w_state_nx = OUT;
                w_lfsr_nx  = {1'b0, r_lfsr[CRC_WIDTH-1:1]};
                w_cnt_nx   = r_cnt + 1'b1;
                if (r_mode == MODE_GEN) begin
                    w_crc_nx   = r_lfsr[0];
                    w_valid_nx = 1'b1;
                end else begin
                    w_mis_nx = r_mis | (Data ^ r_lfsr[0]);
                end
            end
            w_finish: begin
                w_state_nx = IDLE;
                w_lfsr_nx  = SEED;
                w_done_nx  = 1'b1;
                w_err_nx   = (r_mode == MODE_CHK) && r_mis;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_mode  <= MODE_GEN;
            r_mis   <= 1'b0;
            r_crc   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_nx;
            r_cnt   <= w_cnt_nx;
            r_mode  <= w_mode_nx;
            r_mis   <= w_mis_nx;
            r_crc   <= w_crc_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    assign CRC   = r_crc;
    assign Valid = r_valid;
    assign Done  = r_done;
    assign Err   = r_err;
    assign Busy  = r_busy;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Randomised bench for crc_serial_engine at 8/16/32-bit widths,
// checked against a textbook reflected-CRC model.
module tb_crc_serial_engine;
    import crc_pkg::*;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST_n = 1'b0;
    logic [N-1:0] act;
    logic [N-1:0] mode;
    logic [N-1:0] dat;
    logic [N-1:0] crc_o;
    logic [N-1:0] val;
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic [N-1:0] busy;

    int checks = 0;
    int errors = 0;

    int unsigned wid  [N] = '{8, 8, 16, 32};
    logic [31:0] taps [N] = '{32'h44, 32'h44,
                              32'(CRC16_CCITT_TAPS), CRC32_TAPS};
    logic [31:0] seed [N] = '{32'h00, 32'hD8,
                              32'(CRC16_CCITT_SEED), CRC32_SEED};

    always #5 CLK = ~CLK;

    crc_serial_engine #(
        .CRC_WIDTH (8),
        .TAPS      (8'h44),
        .SEED      (8'h00)
    ) u_dut0 (
        .CLK (CLK), .RST_n (RST_n),
        .Active (act[0]), .Mode (mode[0]), .Data (dat[0]),
        .CRC (crc_o[0]), .Valid (val[0]), .Done (done[0]),
        .Err (err[0]), .Busy (busy[0])
    );

    crc_serial_engine u_dut1 (
        .CLK (CLK), .RST_n (RST_n),
        .Active (act[1]), .Mode (mode[1]), .Data (dat[1]),
        .CRC (crc_o[1]), .Valid (val[1]), .Done (done[1]),
        .Err (err[1]), .Busy (busy[1])
    );

    crc_serial_engine #(
        .CRC_WIDTH (16),
        .TAPS      (CRC16_CCITT_TAPS),
        .SEED      (CRC16_CCITT_SEED)
    ) u_dut2 (
        .CLK (CLK), .RST_n (RST_n),
        .Active (act[2]), .Mode (mode[2]), .Data (dat[2]),
        .CRC (crc_o[2]), .Valid (val[2]), .Done (done[2]),
        .Err (err[2]), .Busy (busy[2])
    );

    crc_serial_engine #(
        .CRC_WIDTH (32),
        .TAPS      (CRC32_TAPS),
        .SEED      (CRC32_SEED)
    ) u_dut3 (
        .CLK (CLK), .RST_n (RST_n),
        .Active (act[3]), .Mode (mode[3]), .Data (dat[3]),
        .CRC (crc_o[3]), .Valid (val[3]), .Done (done[3]),
        .Err (err[3]), .Busy (busy[3])
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Classic reflected CRC: shift right, XOR the full polynomial on fb.
    function automatic logic [31:0] ref_crc(input int k,
                                            input logic [63:0] bits,
                                            input int len);
        logic [31:0] c;
        logic [31:0] poly;
        c    = seed[k];
        poly = taps[k] | (32'h1 << (wid[k] - 1));
        for (int i = 0; i < len; i++) begin
            if (c[0] ^ bits[i]) c = (c >> 1) ^ poly;
            else                c = c >> 1;
        end
        return c;
    endfunction

    task automatic chk_idle_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_crc"},   crc_o[k], 0);
            chk({tag, "_valid"}, val[k],   0);
            chk({tag, "_done"},  done[k],  0);
            chk({tag, "_err"},   err[k],   0);
            chk({tag, "_busy"},  busy[k],  0);
        end
    endtask

    // Runs one frame on instance k; returns early before tail edge
    // abort_at so the caller can abort or reset there.
    task automatic do_frame(input int k, input logic md,
                            input logic [63:0] bits, input int len,
                            input int flip, input int abort_at,
                            input int gap,
                            output logic [31:0] stream);
        logic [31:0] exp;
        logic [31:0] rx;
        logic        exp_err;
        int          w;
        w       = int'(wid[k]);
        exp     = ref_crc(k, bits, len);
        rx      = exp;
        exp_err = 1'b0;
        if (flip >= 0) begin
            rx[flip] = ~rx[flip];
            exp_err  = (md == MODE_CHK);
        end
        stream  = '0;
        act[k]  = 1'b1;
        mode[k] = md;
        for (int i = 0; i < len; i++) begin
            dat[k] = bits[i];
            @(negedge CLK);
            mode[k] = 1'($urandom);
            if (i == 0) chk("err_clr", err[k], 0);
            chk("busy_calc",  busy[k], 1);
            chk("valid_calc", val[k],  0);
            chk("done_calc",  done[k], 0);
        end
        act[k] = 1'b0;
        for (int t = 0; t < w; t++) begin
            if (t == abort_at) return;
            dat[k] = (md == MODE_CHK) ? rx[t] : 1'($urandom);
            @(negedge CLK);
            if (md == MODE_GEN) begin
                stream[t] = crc_o[k];
                chk("valid_gen", val[k], 1);
                chk("crc_bit", crc_o[k], exp[t]);
            end else begin
                chk("valid_chk", val[k], 0);
            end
            chk("done_tail", done[k], 0);
            chk("busy_tail", busy[k], 1);
        end
        dat[k] = 1'($urandom);
        @(negedge CLK);
        chk("done_pulse", done[k], 1);
        chk("valid_end",  val[k],  0);
        chk("crc_end",    crc_o[k], 0);
        chk("err_end",    err[k],  exp_err);
        chk("busy_end",   busy[k], 0);
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            chk("done_once", done[k], 0);
            chk("err_hold",  err[k],  exp_err);
            chk("idle_busy", busy[k], 0);
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [63:0] b;
        logic        md;
        int          len;
        int          flip;
        int          ab;
        act  = '0;
        mode = '0;
        dat  = '0;
        repeat (2) @(negedge CLK);
        chk_idle_all("reset");
        RST_n = 1'b1;

        // Zero-length frame: nothing happens.
        dat = '1;
        repeat (3) @(negedge CLK);
        chk_idle_all("zero_len");
        dat = '0;

        // T1 / T2: known single-bit frames.
        do_frame(0, MODE_GEN, 64'h1, 1, -1, -1, 2, s);
        chk("t1_stream", s, 32'hC4);
        do_frame(1, MODE_GEN, 64'h0, 1, -1, -1, 1, s);
        chk("t2_stream", s, 32'h6C);

        // T3: check mode, good then corrupted bit 3.
        do_frame(0, MODE_CHK, 64'h1, 1, -1, -1, 2, s);
        do_frame(0, MODE_CHK, 64'h1, 1, 3, -1, 4, s);
        b = {$urandom, $urandom};
        do_frame(0, MODE_GEN, b, 20, -1, -1, 1, s);

        // T4: abort during generate tail bit 4.
        b = {$urandom, $urandom};
        do_frame(0, MODE_GEN, b, 13, -1, 4, 0, s);
        b = {$urandom, $urandom};
        do_frame(0, MODE_GEN, b, 17, -1, -1, 1, s);

        // T5: asynchronous reset in the middle of the tail.
        b = {$urandom, $urandom};
        do_frame(0, MODE_GEN, b, 9, -1, 3, 0, s);
        #2 RST_n = 1'b0;
        #1;
        chk("rst_crc",   crc_o[0], 0);
        chk("rst_valid", val[0],   0);
        chk("rst_done",  done[0],  0);
        chk("rst_err",   err[0],   0);
        chk("rst_busy",  busy[0],  0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        do_frame(0, MODE_GEN, 64'h1, 1, -1, -1, 1, s);
        chk("t5_stream", s, 32'hC4);

        // T6: back-to-back frames, Active back on the Done cycle.
        b = {$urandom, $urandom};
        do_frame(1, MODE_GEN, b, 11, -1, -1, 0, s);
        b = {$urandom, $urandom};
        do_frame(1, MODE_CHK, b, 7, -1, -1, 0, s);
        do_frame(1, MODE_GEN, 64'h0, 1, -1, -1, 1, s);
        chk("b2b_stream", s, 32'h6C);

        // Random frames on every width.
        for (int n = 0; n < 40; n++) begin
            int k;
            k    = (n < 8) ? (n % 2) : 2 + (n % 2);
            md   = 1'($urandom);
            len  = $urandom_range(1, 64);
            b    = {$urandom, $urandom};
            flip = -1;
            if (md == MODE_CHK && $urandom_range(0, 1) == 1)
                flip = $urandom_range(0, int'(wid[k]) - 1);
            ab = -1;
            if ($urandom_range(0, 5) == 0)
                ab = $urandom_range(0, int'(wid[k]) - 1);
            do_frame(k, md, b, len, flip, ab, $urandom_range(0, 2), s);
        end
        act = '0;
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
